// File: rtl/ide_mgmt_engine_if.sv
// Host command/response, Gayle management, buffer host-port and request lines
// of ide_mgmt_engine; master is the engine side, slave the host/gayle side.
interface ide_mgmt_engine_if #(
  parameter int unsigned BUF_AW = 8
);
  logic [5:0]        ide_req;
  logic [4:0]        ide_address;
  logic              ide_read;
  logic              ide_write;
  logic [15:0]       ide_writedata;
  logic [15:0]       ide_readdata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [4:0]        cmd_addr;
  logic [15:0]       cmd_wdata;
  logic [BUF_AW-1:0] cmd_baddr;
  logic [BUF_AW-1:0] cmd_count;
  logic              rsp_valid;
  logic [15:0]       rsp_data;
  logic [BUF_AW-1:0] buf_addr;
  logic              buf_we;
  logic [15:0]       buf_wdata;
  logic [15:0]       buf_rdata;
  logic [5:0]        req_pending;
  logic [5:0]        req_ack;
  logic              host_irq;

  modport master (
    input  ide_req, ide_readdata, cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_baddr,
           cmd_count, buf_addr, buf_we, buf_wdata, req_ack,
    output ide_address, ide_read, ide_write, ide_writedata, cmd_ready, rsp_valid,
           rsp_data, buf_rdata, req_pending, host_irq
  );

  modport slave (
    output ide_req, ide_readdata, cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_baddr,
           cmd_count, buf_addr, buf_we, buf_wdata, req_ack,
    input  ide_address, ide_read, ide_write, ide_writedata, cmd_ready, rsp_valid,
           rsp_data, buf_rdata, req_pending, host_irq
  );
endinterface

// File: rtl/ide_mgmt_engine.sv
// Host-side engine for the Gayle IDE management port: single register ops,
// autonomous sector bursts through a dual-port buffer, and request latching.
module ide_mgmt_engine #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BUF_AW = 8
) (
  input logic               clk,
  input logic               reset,
  ide_mgmt_engine_if.master bus
);
  localparam int unsigned DEPTH = 1 << BUF_AW;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned REM_W = BUF_AW + 1;

  typedef enum logic [3:0] {
    IDLE, RREG, RWAIT, WREG, BRD, BRD_WAIT, BWR_PRE, BWR, DONE
  } state_t;

  state_t            state_q;
  logic [15:0]       wdata_q;
  logic [BUF_AW-1:0] ptr_q;
  logic [REM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        ide_address_q;
  logic              ide_read_q;
  logic              ide_write_q;
  logic [15:0]       ide_writedata_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_data_q;
  logic [15:0]       buf_rdata_q;
  logic [15:0]       pf_q;
  logic [5:0]        req_prev_q;
  logic [5:0]        req_pending_q;
  logic [5:0]        req_pending_d;
  logic              host_irq_q;
  logic [15:0]       mem [DEPTH];

  logic accept_c;
  logic rd_hit_c;
  logic eng_we_c;

  assign accept_c = bus.cmd_valid && cmd_ready_q && (state_q == IDLE);
  assign rd_hit_c = (cnt_q == CNT_W'(RD_LAT));
  assign eng_we_c = (state_q == BRD_WAIT) && rd_hit_c;

  // Command sequencer; strobes default low and are re-armed only by the active state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wdata_q         <= '0;
      ptr_q           <= '0;
      rem_q           <= '0;
      cnt_q           <= '0;
      ide_address_q   <= '0;
      ide_read_q      <= 1'b0;
      ide_write_q     <= 1'b0;
      ide_writedata_q <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      ide_read_q  <= 1'b0;
      ide_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            cmd_ready_q   <= 1'b0;
            ide_address_q <= bus.cmd_addr;
            wdata_q       <= bus.cmd_wdata;
            ptr_q         <= bus.cmd_baddr;
            rem_q         <= (bus.cmd_count == '0) ? REM_W'(DEPTH) : REM_W'(bus.cmd_count);
            unique case (bus.cmd_op)
              2'd0:    state_q <= RREG;
              2'd1:    state_q <= WREG;
              2'd2:    state_q <= BRD;
              default: state_q <= BWR_PRE;
            endcase
          end
        end
        RREG: begin
          ide_read_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= RWAIT;
        end
        RWAIT: begin
          if (rd_hit_c) begin
            rsp_data_q <= bus.ide_readdata;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WREG: begin
          ide_write_q     <= 1'b1;
          ide_writedata_q <= wdata_q;
          state_q         <= DONE;
        end
        BRD: begin
          ide_read_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= BRD_WAIT;
        end
        BRD_WAIT: begin
          // Next read issues on the capture edge so a word takes RD_LAT+1 cycles.
          if (rd_hit_c) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            cnt_q <= '0;
            if (rem_q == REM_W'(1)) state_q <= DONE;
            else                    ide_read_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BWR_PRE: begin
          ptr_q   <= ptr_q + 1'b1;
          state_q <= BWR;
        end
        BWR: begin
          ide_write_q     <= 1'b1;
          ide_writedata_q <= pf_q;
          ptr_q           <= ptr_q + 1'b1;
          rem_q           <= rem_q - 1'b1;
          if (rem_q == REM_W'(1)) state_q <= DONE;
        end
        DONE: begin
          rsp_valid_q <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sector buffer: engine write is ordered last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdata;
    if (eng_we_c)   mem[ptr_q]        <= bus.ide_readdata;
    buf_rdata_q <= mem[bus.buf_addr];
    pf_q        <= mem[ptr_q];
  end

  // A fresh request edge beats a simultaneous acknowledge.
  always_comb begin
    req_pending_d = (req_pending_q & ~bus.req_ack) | (bus.ide_req & ~req_prev_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_prev_q    <= '0;
      req_pending_q <= '0;
      host_irq_q    <= 1'b0;
    end else begin
      req_prev_q    <= bus.ide_req;
      req_pending_q <= req_pending_d;
      host_irq_q    <= |req_pending_q;
    end
  end

  assign bus.ide_address   = ide_address_q;
  assign bus.ide_read      = ide_read_q;
  assign bus.ide_write     = ide_write_q;
  assign bus.ide_writedata = ide_writedata_q;
  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.buf_rdata     = buf_rdata_q;
  assign bus.req_pending   = req_pending_q;
  assign bus.host_irq      = host_irq_q;
endmodule

// File: tb/tb_ide_mgmt_engine.sv
// Scoreboard bench for ide_mgmt_engine with a Gayle read-latency model and host buffer model.
module tb_ide_mgmt_engine;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned BUF_AW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ide_mgmt_engine_if #(.BUF_AW(BUF_AW)) bus ();

  ide_mgmt_engine #(.RD_LAT(RD_LAT), .BUF_AW(BUF_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_cnt = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int wr_run = 0;
  int wr_run_max = 0;
  int overlap_cnt = 0;
  logic [4:0]  rd_addr_last = '0;
  logic [15:0] last_rd = '0;
  logic [15:0] buf_m [256];

  logic [15:0] gayle_q [$];
  logic [31:0] exp_wr_q [$];
  logic [15:0] exp_rsp_q [$];
  int          rd_cyc_q [$];

  logic        rd_v [3];
  logic [15:0] rd_d [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Gayle read path: data valid RD_LAT cycles after the ide_read cycle.
  always @(posedge clk) begin
    rd_v[0] <= bus.ide_read;
    if (bus.ide_read) begin
      if (gayle_q.size() != 0) rd_d[0] <= gayle_q.pop_front();
      else                     rd_d[0] <= 16'hDEAD;
    end
    for (int i = 1; i < 3; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_d[i] <= rd_d[i-1];
    end
  end
  assign bus.ide_readdata = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : 16'hDEAD;

  // Output monitor and scoreboard pops.
  always @(negedge clk) begin
    if (bus.ide_read && bus.ide_write) overlap_cnt++;
    if (bus.ide_read) begin
      rd_pulses++;
      rd_cyc_q.push_back(cyc);
      rd_addr_last = bus.ide_address;
    end
    if (bus.ide_write) begin
      wr_pulses++;
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
      if (exp_wr_q.size() != 0)
        check("ide_write", {11'd0, bus.ide_address, bus.ide_writedata}, exp_wr_q.pop_front());
      else
        check("ide_write_unexpected", {11'd0, bus.ide_address, bus.ide_writedata}, 32'hFFFF_FFFF);
    end else begin
      wr_run = 0;
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_rsp_q.size() != 0) check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_rsp_q.pop_front()});
      else                       check("rsp_unexpected", {16'd0, bus.rsp_data}, 32'hFFFF_FFFF);
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] wd,
                          input logic [7:0] ba, input logic [7:0] cnt, input bit hold);
    int k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_baddr = ba;
    bus.cmd_count = cnt;
    acc_cyc = cyc;
    @(negedge clk);
    if (hold) begin
      bus.cmd_op   = 2'd0;
      bus.cmd_addr = 5'h1F;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0, input int budget);
    int k = 0;
    while (rsp_cnt == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("rsp_timeout", 32'(rsp_cnt - n0), 32'd1);
  endtask

  task automatic buf_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.buf_we    = 1'b1;
    bus.buf_addr  = a;
    bus.buf_wdata = d;
    buf_m[a]      = d;
    @(negedge clk);
    bus.buf_we = 1'b0;
  endtask

  task automatic buf_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
    @(negedge clk);
    bus.buf_addr = a;
    @(negedge clk);
    check(tag, {16'd0, bus.buf_rdata}, {16'd0, exp});
  endtask

  initial begin
    int n0;
    int p0;
    int k;
    bus.ide_req   = '0;
    bus.req_ack   = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_baddr = '0;
    bus.cmd_count = '0;
    bus.buf_addr  = '0;
    bus.buf_we    = 1'b0;
    bus.buf_wdata = '0;
    for (int i = 0; i < 256; i++) buf_m[i] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_strobes", {30'd0, bus.ide_read, bus.ide_write}, 32'd0);
    check("rst_rsp", {15'd0, bus.rsp_valid, bus.rsp_data}, 32'd0);
    check("rst_ide_bus", {11'd0, bus.ide_address, bus.ide_writedata}, 32'd0);
    check("rst_req", {25'd0, bus.host_irq, bus.req_pending}, 32'd0);
    reset = 1'b0;

    // Register read of 5'h17
    gayle_q.push_back(16'h50A0);
    last_rd = 16'h50A0;
    exp_rsp_q.push_back(last_rd);
    n0 = rsp_cnt; p0 = rd_pulses;
    send_cmd(2'd0, 5'h17, 16'h0000, 8'h00, 8'h00, 1'b0);
    wait_rsp(n0, 50);
    check("rreg_pulses", 32'(rd_pulses - p0), 32'd1);
    check("rreg_addr", {27'd0, rd_addr_last}, 32'h17);

    // Register write, with cmd_valid held into the busy cycle (must be ignored)
    exp_wr_q.push_back({11'd0, 5'h0A, 16'h1234});
    exp_rsp_q.push_back(last_rd);
    n0 = rsp_cnt; p0 = rd_pulses;
    send_cmd(2'd1, 5'h0A, 16'h1234, 8'h00, 8'h00, 1'b1);
    wait_rsp(n0, 50);
    check("wreg_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    repeat (4) @(negedge clk);
    check("busy_cmd_ignored", {16'(rd_pulses - p0), 16'(rsp_cnt - n0)}, {16'd0, 16'd1});

    // Burst read of 4 words wrapping past the top of the buffer
    buf_write(8'h02, 16'h5555);
    for (int i = 0; i < 4; i++) gayle_q.push_back(16'hA001 + 16'(i));
    exp_rsp_q.push_back(last_rd);
    rd_cyc_q.delete();
    n0 = rsp_cnt;
    send_cmd(2'd2, 5'h10, 16'h0000, 8'hFE, 8'd4, 1'b0);
    wait_rsp(n0, 100);
    check("brd_pulse_count", 32'(rd_cyc_q.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      if (rd_cyc_q.size() > i) check("brd_pulse_spacing", 32'(rd_cyc_q[i] - rd_cyc_q[i-1]), 32'(RD_LAT + 1));
    for (int i = 0; i < 4; i++) buf_m[8'(8'hFE + i)] = 16'hA001 + 16'(i);
    buf_read("brd_buf_FE", 8'hFE, buf_m[8'hFE]);
    buf_read("brd_buf_FF", 8'hFF, buf_m[8'hFF]);
    buf_read("brd_buf_00", 8'h00, buf_m[8'h00]);
    buf_read("brd_buf_01", 8'h01, buf_m[8'h01]);
    buf_read("brd_buf_02_untouched", 8'h02, buf_m[8'h02]);

    // Host and engine write the same buffer word in the same cycle
    gayle_q.push_back(16'hC0DE);
    exp_rsp_q.push_back(last_rd);
    n0 = rsp_cnt;
    send_cmd(2'd2, 5'h10, 16'h0000, 8'h40, 8'd1, 1'b0);
    k = 0;
    while (!bus.ide_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (RD_LAT) @(negedge clk);
    bus.buf_we = 1'b1; bus.buf_addr = 8'h40; bus.buf_wdata = 16'hBEEF;
    @(negedge clk);
    bus.buf_we = 1'b0;
    wait_rsp(n0, 50);
    buf_m[8'h40] = 16'hC0DE;
    buf_read("collision_engine_wins", 8'h40, 16'hC0DE);

    // Request latch: rise with simultaneous ack, then ack, level stays high
    @(negedge clk);
    bus.ide_req = 6'h10; bus.req_ack = 6'h10;
    @(negedge clk);
    bus.req_ack = 6'h00;
    check("req_set_wins", {26'd0, bus.req_pending}, 32'h10);
    @(negedge clk);
    check("irq_follows", {31'd0, bus.host_irq}, 32'd1);
    bus.req_ack = 6'h10;
    @(negedge clk);
    bus.req_ack = 6'h00;
    check("req_acked", {26'd0, bus.req_pending}, 32'h00);
    repeat (3) @(negedge clk);
    check("req_level_no_reset", {25'd0, bus.host_irq, bus.req_pending}, 32'd0);
    bus.ide_req = 6'h00;

    // Burst write, count 0 = full 256-word buffer
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.buf_we = 1'b1; bus.buf_addr = 8'(i); bus.buf_wdata = 16'(i * 16'h0101) ^ 16'h3C00;
      buf_m[i] = 16'(i * 16'h0101) ^ 16'h3C00;
    end
    @(negedge clk);
    bus.buf_we = 1'b0;
    for (int i = 0; i < 256; i++) exp_wr_q.push_back({11'd0, 5'h1C, buf_m[8'(8'h80 + i)]});
    exp_rsp_q.push_back(last_rd);
    n0 = rsp_cnt; p0 = wr_pulses; wr_run_max = 0;
    send_cmd(2'd3, 5'h1C, 16'h0000, 8'h80, 8'd0, 1'b0);
    wait_rsp(n0, 400);
    check("bwr_words", 32'(wr_pulses - p0), 32'd256);
    check("bwr_consecutive", 32'(wr_run_max), 32'd256);

    // Reset during a burst read
    bus.ide_req = 6'h01;
    repeat (2) @(negedge clk);
    check("pending_before_reset", {26'd0, bus.req_pending}, 32'h01);
    for (int i = 0; i < 8; i++) gayle_q.push_back(16'h7100 + 16'(i));
    n0 = rsp_cnt;
    send_cmd(2'd2, 5'h05, 16'h0000, 8'h10, 8'd8, 1'b0);
    k = 0; p0 = 0;
    while (p0 < 2 && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.ide_read) p0++;
    end
    #1 reset = 1'b1;
    #1;
    check("abort_strobes", {30'd0, bus.ide_read, bus.ide_write}, 32'd0);
    check("abort_ready_pending", {25'd0, bus.cmd_ready, bus.req_pending}, 32'h40);
    bus.ide_req = 6'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    gayle_q.delete();
    last_rd = 16'h0000;
    repeat (3) @(negedge clk);
    check("abort_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    buf_read("abort_buf_kept", 8'h10, 16'h7100);
    buf_read("abort_buf_next", 8'h11, buf_m[8'h11]);

    check("strobe_overlap", 32'(overlap_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_wr_q.size() + exp_rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
